// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM result and owns the single register-file write port.
// Multicycle-unit results queue in a small FIFO, with anti-starvation forcing against MEM writes.
module wb_stage #(
  parameter int unsigned FU_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_stall_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] mem_in,
  input  logic [3:0]  Z_in,
  input  logic [3:0]  cntrl_w_in,
  input  logic        fu_valid_in,
  input  logic [3:0]  fu_Z_in,
  input  logic [31:0] fu_data_in,
  output logic        fu_stall_out,
  output logic        wb_stall_out,
  output logic        rf_we_out,
  output logic [3:0]  rf_waddr_out,
  output logic [31:0] rf_wdata_out,
  output logic        halt_out,
  output logic        overflow_out,
  output logic [31:0] retire_cnt_out
);
  localparam int unsigned PtrW = (FU_FIFO_DEPTH > 1) ? $clog2(FU_FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FU_FIFO_DEPTH + 1);
  localparam int unsigned StW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic            valid_q, regwrite_q, memtoreg_q, halt_instr_q;
  logic [31:0]     alu_q, mem_q;
  logic [3:0]      z_q;
  logic [3:0]      fifo_z_q    [FU_FIFO_DEPTH];
  logic [31:0]     fifo_data_q [FU_FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            halt_q, overflow_q;
  logic [31:0]     retire_cnt_q;

  logic mem_req, fifo_req, fifo_full, force_fifo;
  logic grant_fifo, grant_mem, wb_hold, wb_retire, push;

  // Bit 2 of the writeback control word carries no meaning in this stage.
  logic unused_reserved;
  assign unused_reserved = cntrl_w_in[2];

  always_comb begin
    mem_req    = valid_q & regwrite_q & (z_q != 4'd0);
    fifo_req   = (count_q != '0);
    fifo_full  = (count_q == CntW'(FU_FIFO_DEPTH));
    force_fifo = fifo_req & (starve_q == StW'(STARVE_LIMIT));
    grant_fifo = force_fifo | (fifo_req & ~mem_req);
    grant_mem  = ~force_fifo & mem_req;
    wb_hold    = force_fifo & mem_req;
    wb_retire  = valid_q & ~wb_hold;
    push       = fu_valid_in & ~fifo_full;
  end

  always_comb begin
    count_d = count_q;
    if (push && !grant_fifo) begin
      count_d = count_q + CntW'(1);
    end else if (!push && grant_fifo) begin
      count_d = count_q - CntW'(1);
    end
    starve_d = '0;
    if (fifo_req && !grant_fifo) begin
      starve_d = (starve_q == StW'(STARVE_LIMIT)) ? starve_q : starve_q + StW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      halt_instr_q <= 1'b0;
      alu_q        <= '0;
      mem_q        <= '0;
      z_q          <= '0;
    end else if (!wb_hold) begin
      valid_q      <= ~mem_stall_in;
      regwrite_q   <= cntrl_w_in[0];
      memtoreg_q   <= cntrl_w_in[1];
      halt_instr_q <= cntrl_w_in[3];
      alu_q        <= alu_in;
      mem_q        <= mem_in;
      z_q          <= Z_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      halt_q       <= 1'b0;
      overflow_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (grant_fifo) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q      <= count_d;
      starve_q     <= starve_d;
      retire_cnt_q <= retire_cnt_q + 32'(wb_retire) + 32'(grant_fifo);
      if (wb_retire && halt_instr_q) begin
        halt_q <= 1'b1;
      end
      if (fu_valid_in && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_z_q[wr_ptr_q]    <= fu_Z_in;
      fifo_data_q[wr_ptr_q] <= fu_data_in;
    end
  end

  always_comb begin
    rf_we_out    = 1'b0;
    rf_waddr_out = '0;
    rf_wdata_out = '0;
    if (grant_fifo) begin
      rf_we_out    = 1'b1;
      rf_waddr_out = fifo_z_q[rd_ptr_q];
      rf_wdata_out = fifo_data_q[rd_ptr_q];
    end else if (grant_mem) begin
      rf_we_out    = 1'b1;
      rf_waddr_out = z_q;
      rf_wdata_out = memtoreg_q ? mem_q : alu_q;
    end
  end

  assign fu_stall_out   = fifo_full;
  assign wb_stall_out   = wb_hold;
  assign halt_out       = halt_q;
  assign overflow_out   = overflow_q;
  assign retire_cnt_out = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_wb_stage;
  localparam int unsigned Depth = 2;
  localparam int unsigned Limit = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_stall_in, fu_valid_in;
  logic [31:0] alu_in, mem_in, fu_data_in;
  logic [3:0]  Z_in, cntrl_w_in, fu_Z_in;
  logic        fu_stall_out, wb_stall_out, rf_we_out, halt_out, overflow_out;
  logic [3:0]  rf_waddr_out;
  logic [31:0] rf_wdata_out, retire_cnt_out;

  always #5 clk = ~clk;

  wb_stage #(.FU_FIFO_DEPTH(Depth), .STARVE_LIMIT(Limit)) dut (
    .clk(clk), .rst(rst), .mem_stall_in(mem_stall_in), .alu_in(alu_in), .mem_in(mem_in),
    .Z_in(Z_in), .cntrl_w_in(cntrl_w_in), .fu_valid_in(fu_valid_in), .fu_Z_in(fu_Z_in),
    .fu_data_in(fu_data_in), .fu_stall_out(fu_stall_out), .wb_stall_out(wb_stall_out),
    .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out), .rf_wdata_out(rf_wdata_out),
    .halt_out(halt_out), .overflow_out(overflow_out), .retire_cnt_out(retire_cnt_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one pending MEM result plus a queue of FU results.
  typedef struct packed {
    logic [3:0]  z;
    logic [31:0] d;
  } fu_t;
  fu_t         fq[$];
  logic        m_valid;
  logic [31:0] m_alu, m_mem, m_cnt;
  logic [3:0]  m_z, m_cw;
  int          m_starve;
  logic        m_halt, m_ovf;

  typedef struct {
    logic        st;
    logic [3:0]  cw;
    logic [3:0]  z;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        we;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Port owner this cycle: 0 none, 1 MEM, 2 FIFO head. hold = MEM entry must wait.
  function automatic int m_grant(output logic hold);
    logic mreq, freq;
    mreq = m_valid && m_cw[0] && (m_z != 4'd0);
    freq = (fq.size() != 0);
    hold = 1'b0;
    if (freq && m_starve == Limit) begin
      hold = mreq;
      return 2;
    end
    if (mreq) return 1;
    if (freq) return 2;
    return 0;
  endfunction

  task automatic m_reset();
    fq.delete();
    m_valid = 0; m_alu = 0; m_mem = 0; m_cnt = 0; m_z = 0; m_cw = 0;
    m_starve = 0; m_halt = 0; m_ovf = 0;
  endtask

  task automatic check_all(string tag);
    logic        hold, we;
    logic [3:0]  a;
    logic [31:0] d;
    int          g;
    g  = m_grant(hold);
    we = (g != 0);
    a  = 4'd0;
    d  = 32'd0;
    if (g == 1) begin
      a = m_z;
      d = m_cw[1] ? m_mem : m_alu;
    end else if (g == 2) begin
      a = fq[0].z;
      d = fq[0].d;
    end
    chk({tag, ".rf_we"}, 32'(rf_we_out), 32'(we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr_out), 32'(a));
    chk({tag, ".rf_wdata"}, rf_wdata_out, d);
    chk({tag, ".wb_stall"}, 32'(wb_stall_out), 32'(hold));
    chk({tag, ".fu_stall"}, 32'(fu_stall_out), 32'(fq.size() == Depth));
    chk({tag, ".halt"}, 32'(halt_out), 32'(m_halt));
    chk({tag, ".overflow"}, 32'(overflow_out), 32'(m_ovf));
    chk({tag, ".retire_cnt"}, retire_cnt_out, m_cnt);
  endtask

  task automatic model_step();
    logic hold, retire;
    int   g;
    fu_t  e;
    g      = m_grant(hold);
    retire = m_valid && !hold;
    m_cnt  = m_cnt + 32'(retire) + 32'(g == 2);
    if (retire && m_cw[3]) m_halt = 1'b1;
    if (fq.size() == 0 || g == 2) m_starve = 0;
    else if (m_starve < Limit) m_starve++;
    // Fullness is judged on occupancy before this cycle's pop.
    if (fu_valid_in) begin
      if (fq.size() == Depth) begin
        m_ovf = 1'b1;
      end else begin
        e.z = fu_Z_in;
        e.d = fu_data_in;
        fq.push_back(e);
      end
    end
    if (g == 2) void'(fq.pop_front());
    if (!hold) begin
      m_valid = !mem_stall_in;
      m_alu   = alu_in;
      m_mem   = mem_in;
      m_z     = Z_in;
      m_cw    = cntrl_w_in;
    end
  endtask

  task automatic drive(logic st, logic [3:0] cw, logic [3:0] z, logic [31:0] alu,
                       logic [31:0] mem, logic fv, logic [3:0] fz, logic [31:0] fd);
    mem_stall_in = st; cntrl_w_in = cw; Z_in = z; alu_in = alu; mem_in = mem;
    fu_valid_in = fv; fu_Z_in = fz; fu_data_in = fd;
  endtask

  task automatic idle();
    drive(1'b1, 4'd0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  // Entered just after a falling edge; asserts reset mid-cycle and checks it without a clock edge.
  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    m_reset();
    check_all("reset_async");
    @(posedge clk);
    @(negedge clk);
    check_all("reset_held");
    idle();
    rst = 1'b1;
  endtask

  int          z;
  logic        seen_a, seen_b, seen_c;
  logic        r_hold;
  int          r_g;

  initial begin
    tbl[0] = '{1'b0, 4'b0011, 4'd3,  32'd12,         32'hDEAD,     1'b1, 4'd3,  32'hDEAD,     32'd0};
    tbl[1] = '{1'b0, 4'b0001, 4'd5,  32'd15,         32'd0,        1'b1, 4'd5,  32'd15,       32'd1};
    tbl[2] = '{1'b0, 4'b0001, 4'd0,  32'd99,         32'd0,        1'b0, 4'd0,  32'd0,        32'd2};
    tbl[3] = '{1'b1, 4'b0001, 4'd6,  32'd1,          32'd0,        1'b0, 4'd0,  32'd0,        32'd3};
    tbl[4] = '{1'b0, 4'b0000, 4'd6,  32'd7,          32'd0,        1'b0, 4'd0,  32'd0,        32'd3};
    tbl[5] = '{1'b0, 4'b0011, 4'd15, 32'd1,          32'h12345678, 1'b1, 4'd15, 32'h12345678, 32'd4};
    tbl[6] = '{1'b0, 4'b0001, 4'd15, 32'hFFFFFFFF,   32'd5,        1'b1, 4'd15, 32'hFFFFFFFF, 32'd5};

    idle();
    apply_reset();

    // Directed MEM-path vectors: load, ALU, r0 suppression, bubble, no-regwrite.
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].st, tbl[i].cw, tbl[i].z, tbl[i].alu, tbl[i].mem, 1'b0, 4'd0, 32'd0);
      tick("tbl");
      chk($sformatf("tbl%0d.we", i), 32'(rf_we_out), 32'(tbl[i].we));
      chk($sformatf("tbl%0d.addr", i), 32'(rf_waddr_out), 32'(tbl[i].a));
      chk($sformatf("tbl%0d.data", i), rf_wdata_out, tbl[i].d);
      chk($sformatf("tbl%0d.cnt", i), retire_cnt_out, tbl[i].cnt);
    end

    // Starvation: FIFO head loses three cycles, then forces through and holds MEM.
    idle();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      z = (i < 4) ? i + 1 : i;
      drive(1'b0, 4'b0001, 4'(z), 32'(z * 3), 32'd0, i == 0, 4'd7, 32'h41200000);
      tick("t4");
      if (i < 3) begin
        chk("t4_mem_wins", 32'(rf_waddr_out), 32'(i + 1));
        chk("t4_no_hold", 32'(wb_stall_out), 32'd0);
      end
      if (i == 3) begin
        chk("t4_forced_addr", 32'(rf_waddr_out), 32'd7);
        chk("t4_forced_data", rf_wdata_out, 32'h41200000);
        chk("t4_hold", 32'(wb_stall_out), 32'd1);
      end
      if (i == 4) begin
        chk("t4_held_we", 32'(rf_we_out), 32'd1);
        chk("t4_held_addr", 32'(rf_waddr_out), 32'd4);
        chk("t4_held_data", rf_wdata_out, 32'd12);
        chk("t4_released", 32'(wb_stall_out), 32'd0);
      end
    end

    // FIFO full and overflow: third result must be dropped and never written.
    idle();
    apply_reset();
    seen_a = 0; seen_b = 0; seen_c = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 4'b0001, 4'((i % 8) + 1), 32'(i), 32'd0, i < 3,
            (i == 0) ? 4'd9 : (i == 1) ? 4'd10 : 4'd11,
            (i == 0) ? 32'hAAAA0001 : (i == 1) ? 32'hBBBB0002 : 32'hBADC0DE0);
      tick("t5");
      if (i == 0) chk("t5_not_full", 32'(fu_stall_out), 32'd0);
      if (i == 1) chk("t5_full", 32'(fu_stall_out), 32'd1);
      if (i == 2) chk("t5_overflow", 32'(overflow_out), 32'd1);
      if (rf_we_out && rf_wdata_out == 32'hAAAA0001 && rf_waddr_out == 4'd9) seen_a = 1;
      if (rf_we_out && rf_wdata_out == 32'hBBBB0002 && rf_waddr_out == 4'd10) seen_b = 1;
      if (rf_we_out && rf_wdata_out == 32'hBADC0DE0) seen_c = 1;
    end
    chk("t5_first_written", 32'(seen_a), 32'd1);
    chk("t5_second_written", 32'(seen_b), 32'd1);
    chk("t5_dropped_never_written", 32'(seen_c), 32'd0);

    // Halt: sticky after the halt entry retires; bubbles add no retirements.
    idle();
    apply_reset();
    drive(1'b0, 4'b1000, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick("t6");
    chk("t6_not_yet", 32'(halt_out), 32'd0);
    idle();
    tick("t6");
    chk("t6_halt", 32'(halt_out), 32'd1);
    chk("t6_cnt", retire_cnt_out, 32'd1);
    for (int i = 0; i < 3; i++) tick("t6");
    chk("t6_halt_sticky", 32'(halt_out), 32'd1);
    chk("t6_cnt_bubbles", retire_cnt_out, 32'd1);

    // Reset while busy: WB valid and one FIFO entry pending.
    idle();
    apply_reset();
    drive(1'b0, 4'b0001, 4'd2, 32'h55, 32'd0, 1'b1, 4'd4, 32'h77);
    tick("t1_setup");
    chk("t1_busy_we", 32'(rf_we_out), 32'd1);
    chk("t1_busy_addr", 32'(rf_waddr_out), 32'd2);
    idle();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      tick("t1_after");
      chk("t1_no_write", 32'(rf_we_out), 32'd0);
    end
    chk("t1_cnt_zero", retire_cnt_out, 32'd0);

    // Randomized traffic, mostly honouring the hold/full handshakes.
    idle();
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      r_g = m_grant(r_hold);
      if (!r_hold || $urandom_range(0, 3) == 0) begin
        mem_stall_in = ($urandom_range(0, 3) == 0);
        cntrl_w_in   = {($urandom_range(0, 31) == 0), 3'($urandom)};
        Z_in         = 4'($urandom_range(0, 15));
        alu_in       = $urandom;
        mem_in       = $urandom;
      end
      fu_valid_in = ($urandom_range(0, 2) == 0) &&
                    ((fq.size() < Depth) || ($urandom_range(0, 7) == 0));
      fu_Z_in     = 4'($urandom_range(0, 15));
      fu_data_in  = $urandom;
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
